imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 10, giving the word-address width of the internal array (1024 words).
REQ-002 The module SHALL have parameter LATENCY, default 1, legal range 1..4, giving the request-to-response delay in cycles.
REQ-003 The module SHALL have parameter NOP_INST, default 32'h00000013, the word returned for erroneous or killed-slot fetches.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 The module SHALL have port fetch_req, input, 1, fetch request strobe from the core PC register.
REQ-007 The module SHALL have port fetch_addr, input, 32, byte address of the requested instruction.
REQ-008 The module SHALL have port kill, input, 1, flush of all in-flight responses on redirect.
REQ-009 The module SHALL have port request_data, output, 32, returned instruction word.
REQ-010 The module SHALL have port fetch_data_valid, output, 1, single-cycle qualifier for request_data.
REQ-011 The module SHALL have port fetch_err, output, 1, qualifies the response as misaligned or out-of-range.
REQ-012 The module SHALL have ports prog_we (input, 1), prog_addr (input, DEPTH_LOG2, word address) and prog_data (input, 32), the program-load write port.
REQ-013 The module SHALL have port resp_count, output, 16, saturating count of delivered responses.

Function
REQ-014 A request SHALL be accepted on every rising edge where fetch_req=1; no backpressure, one request per cycle sustained.
REQ-015 On acceptance the array word at fetch_addr[DEPTH_LOG2+1:2] SHALL be read and entered into a LATENCY-stage pipeline with valid and err bits.
REQ-016 The response for a request accepted at edge N SHALL drive fetch_data_valid=1 during the cycle after edge N+LATENCY-1, for exactly one cycle, in request order.
REQ-017 fetch_addr[1:0]!=0 SHALL produce a response with request_data=NOP_INST and fetch_err=1.
REQ-018 Any nonzero fetch_addr bit above bit DEPTH_LOG2+1 SHALL produce a response with request_data=NOP_INST and fetch_err=1.
REQ-019 When fetch_data_valid=0, request_data SHALL be NOP_INST and fetch_err SHALL be 0.
REQ-020 kill=1 at an edge SHALL clear the valid bit of every in-flight stage; no response accepted before that edge is ever delivered.
REQ-021 A request presented in the same cycle as kill SHALL be accepted and delivered normally (it is the redirected fetch).
REQ-022 prog_we=1 SHALL write prog_data into word prog_addr at the edge.
REQ-023 When a write and a read target the same word at the same edge, the read SHALL return the old contents.
REQ-024 resp_count SHALL increment by 1 on each delivered response, including fetch_err responses, and SHALL saturate at 16'hFFFF.
REQ-025 Killed responses SHALL NOT increment resp_count.

Reset
REQ-026 rst=1 SHALL immediately clear all pipeline valid and err bits, set fetch_data_valid=0, fetch_err=0, request_data=NOP_INST and resp_count=0, independent of clk.
REQ-027 Requests, kill and writes SHALL be ignored while rst=1; in-flight responses at reset assertion SHALL be discarded.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 The first request SHALL be accepted at the first rising edge with rst=0.

Verification
REQ-030 Program words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F; LATENCY=1; fetch 0x0,0x4,0x8,0xC back-to-back -> four consecutive valid cycles returning those words in order, resp_count=4.
REQ-031 Fetch 0x2, then 0x00001000 with DEPTH_LOG2=10 -> two responses, each request_data=32'h00000013, fetch_err=1.
REQ-032 LATENCY=3, fetch 0x0,0x4 then assert kill with fetch 0x8 in the same cycle -> only the 0x8 word is delivered, resp_count=1.
REQ-033 Same edge: prog_we to word 2 with 32'hDEADBEEF and fetch 0x8 -> old word returned; a later fetch 0x8 -> 32'hDEADBEEF.
REQ-034 Assert rst asynchronously mid-cycle with two responses in flight (LATENCY=2) -> outputs return to reset values at once, no response after deassertion, array contents retained.
REQ-035 Preload resp_count near saturation by 65540 continuous fetches -> resp_count holds at 16'hFFFF.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with fixed-latency fetch pipeline, kill flush and saturating response counter
module imem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  kill,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [31:0]           prog_data,
    output logic [31:0]           request_data,
    output logic                  fetch_data_valid,
    output logic                  fetch_err,
    output logic [15:0]           resp_count
);
    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic [LATENCY-1:0]    r_vld;
    logic [LATENCY-1:0]    r_err;
    logic [31:0]           r_dat [LATENCY];
    logic [15:0]           r_cnt;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    assign w_err = (|fetch_addr[1:0]) || (|fetch_addr[31:DEPTH_LOG2+2]);
    assign w_idx = fetch_addr[DEPTH_LOG2+1:2];
    always_ff @(posedge clk)
        if (!rst && prog_we) r_mem[prog_addr] <= prog_data;
    // stage 0 always takes the new request, so a fetch alongside kill survives the flush
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            r_cnt <= '0;
            for (int i = 0; i < LATENCY; i++) r_dat[i] <= NOP_INST;
        end else begin
            r_vld[0] <= fetch_req;
            r_err[0] <= w_err;
            r_dat[0] <= w_err ? NOP_INST : r_mem[w_idx];
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1] && !kill;
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            if (r_vld[LATENCY-1] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
    assign fetch_data_valid = r_vld[LATENCY-1];
    assign fetch_err        = r_vld[LATENCY-1] && r_err[LATENCY-1];
    assign request_data     = r_vld[LATENCY-1] ? r_dat[LATENCY-1] : NOP_INST;
    assign resp_count       = r_cnt;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks on three instances with LATENCY 1, 2 and 3
module tb_imem_responder;
    logic        clk = 0;
    logic        rst = 1;
    logic        fetch_req = 0;
    logic [31:0] fetch_addr = '0;
    logic        kill = 0;
    logic        prog_we = 0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] d1, d2, d3;
    logic        v1, v2, v3, e1, e2, e3;
    logic [15:0] c1, c2, c3;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
    localparam logic [31:0] NOP = 32'h00000013;

    imem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .kill(kill), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .request_data(d1), .fetch_data_valid(v1), .fetch_err(e1), .resp_count(c1));
    imem_responder #(.LATENCY(2)) u2 (.clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .kill(kill), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .request_data(d2), .fetch_data_valid(v2), .fetch_err(e2), .resp_count(c2));
    imem_responder #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .kill(kill), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .request_data(d3), .fetch_data_valid(v3), .fetch_err(e3), .resp_count(c3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        #2 rst = 1;
        #1 rst = 0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1;
        fetch_addr = a;
    endtask

    initial begin
        #1;
        chk("rst_valid", {31'b0, v1}, 0);
        chk("rst_err", {31'b0, e1}, 0);
        chk("rst_data", d1, NOP);
        chk("rst_cnt", {16'b0, c1}, 0);
        fetch(0);
        tick();
        chk("rst_ignores_req", {31'b0, v1}, 0);
        fetch_req = 0;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            prog_we = 1;
            prog_addr = 10'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we = 0;
        pulse_rst();
        // four back-to-back fetches, LATENCY=1
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            tick();
            chk("seq_valid", {31'b0, v1}, 1);
            chk("seq_data", d1, prog[i]);
            chk("seq_err", {31'b0, e1}, 0);
        end
        fetch_req = 0;
        tick();
        chk("seq_idle_valid", {31'b0, v1}, 0);
        chk("seq_idle_data", d1, NOP);
        chk("seq_cnt", {16'b0, c1}, 4);
        // misaligned and out-of-range
        fetch(32'h2);
        tick();
        chk("misalign_valid", {31'b0, v1}, 1);
        chk("misalign_data", d1, NOP);
        chk("misalign_err", {31'b0, e1}, 1);
        fetch(32'h00001000);
        tick();
        chk("range_valid", {31'b0, v1}, 1);
        chk("range_data", d1, NOP);
        chk("range_err", {31'b0, e1}, 1);
        fetch_req = 0;
        tick();
        chk("err_idle_err", {31'b0, e1}, 0);
        chk("err_cnt", {16'b0, c1}, 6);
        // kill with redirected fetch, LATENCY=3
        pulse_rst();
        chk("pulse_cnt", {16'b0, c3}, 0);
        fetch(32'h0);
        tick();
        fetch(32'h4);
        tick();
        fetch(32'h8);
        kill = 1;
        tick();
        fetch_req = 0;
        kill = 0;
        chk("kill_v0", {31'b0, v3}, 0);
        tick();
        chk("kill_v1", {31'b0, v3}, 0);
        tick();
        chk("kill_redirect_valid", {31'b0, v3}, 1);
        chk("kill_redirect_data", d3, prog[2]);
        tick();
        chk("kill_after_valid", {31'b0, v3}, 0);
        chk("kill_cnt", {16'b0, c3}, 1);
        // write and read same word at the same edge
        prog_we = 1;
        prog_addr = 10'd2;
        prog_data = 32'hDEADBEEF;
        fetch(32'h8);
        tick();
        prog_we = 0;
        chk("rdw_old", d1, prog[2]);
        tick();
        chk("rdw_new", d1, 32'hDEADBEEF);
        fetch_req = 0;
        tick();
        // async reset with responses in flight, LATENCY=2
        fetch(32'h0);
        tick();
        fetch(32'h4);
        tick();
        fetch_req = 0;
        chk("l2_valid", {31'b0, v2}, 1);
        chk("l2_data", d2, prog[0]);
        #2 rst = 1;
        #1;
        chk("async_valid", {31'b0, v2}, 0);
        chk("async_data", d2, NOP);
        chk("async_cnt", {16'b0, c2}, 0);
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_quiet", {31'b0, v2}, 0);
        end
        fetch(32'h8);
        tick();
        fetch_req = 0;
        chk("retained_l1", d1, 32'hDEADBEEF);
        tick();
        chk("retained_l2", d2, 32'hDEADBEEF);
        // saturation of the response counter
        pulse_rst();
        fetch(32'h0);
        repeat (65535) tick();
        chk("sat_near", {16'b0, c1}, 32'hFFFE);
        tick();
        chk("sat_reach", {16'b0, c1}, 32'hFFFF);
        repeat (4) tick();
        chk("sat_hold", {16'b0, c1}, 32'hFFFF);
        fetch_req = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
